// File: rtl/counter_pkg.sv
// Shared constants, types and helpers for the lab counter family.
// Pure declarations: no logic, no latency, no flow control.
package counter_pkg;

  localparam int COUNTER_W_DEFAULT = 2;

  typedef logic [1:0] count2_t;

  // Largest value an n-bit count can hold (2^n - 1), valid for n in 1..32.
  function automatic logic [31:0] count_max(input int unsigned n);
    logic [32:0] full;
    full = (33'd1 << n) - 33'd1;
    return full[31:0];
  endfunction

endpackage

// File: rtl/down_step.sv
// Combinational N-bit decrement, y = a - 1 modulo 2^N (0 wraps to all-ones).
// Zero latency; no flow control, the result is valid whenever a is.
module down_step #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  assign y = a - N'(1);

endmodule

// File: rtl/regressive_counter_logic.sv
// N-bit down counter clocked by decrement, with an async active-low preset from in.
// Updates one clock-to-q after each decrement rise; no backpressure, wraps 0 -> all-ones.
module regressive_counter_logic
  import counter_pkg::*;
#(
  parameter int N = COUNTER_W_DEFAULT
) (
  input  logic [N-1:0] in,
  input  logic         decrement,
  input  logic         reset,
  output logic [N-1:0] out
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;
  logic [N-1:0] count_dec;

  down_step #(
    .N (N)
  ) u_down_step (
    .a (count_q),
    .y (count_dec)
  );

  always_comb begin
    count_d = count_dec;
  end

  // Preset is both the async load and the priority term at a clock edge while
  // reset is held low, so a changed in is picked up on the next decrement rise.
  always_ff @(posedge decrement or negedge reset) begin
    if (!reset) begin
      count_q <= in;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

endmodule

// File: tb/tb_regressive_counter_logic.sv
// Self-checking bench for regressive_counter_logic at N=2 and N=4 against a modular-arithmetic model.
module tb_regressive_counter_logic;
  import counter_pkg::*;

  logic [1:0] in2;
  logic       dec2;
  logic       rst2;
  logic [1:0] out2;

  logic [3:0] in4;
  logic       dec4;
  logic       rst4;
  logic [3:0] out4;

  int tests_run;
  int tests_failed;
  int m2;
  int m4;

  regressive_counter_logic #(.N(2)) dut2 (
    .in        (in2),
    .decrement (dec2),
    .reset     (rst2),
    .out       (out2)
  );

  regressive_counter_logic #(.N(4)) dut4 (
    .in        (in4),
    .decrement (dec4),
    .reset     (rst4),
    .out       (out4)
  );

  // Model step: one count down modulo 2^n.
  function automatic int model_dec(input int v, input int n);
    int modulus;
    modulus = int'(count_max(n)) + 1;
    return (v + modulus - 1) % modulus;
  endfunction

  task automatic pulse2();
    dec2 = 1'b1;
    #5;
    dec2 = 1'b0;
    #5;
  endtask

  task automatic pulse4();
    dec4 = 1'b1;
    #5;
    dec4 = 1'b0;
    #5;
  endtask

  task automatic test_reset();
    in2 = 2'd3;
    in4 = 4'd9;
    #3;
    rst2 = 1'b0;
    rst4 = 1'b0;
    #1;
    tests_run++;
    if (out2 !== 2'd3) begin
      tests_failed++;
      $display("FAIL reset_async_n2: got %0d expected 3", out2);
    end
    tests_run++;
    if (out4 !== 4'd9) begin
      tests_failed++;
      $display("FAIL reset_async_n4: got %0d expected 9", out4);
    end
    #2;
    rst2 = 1'b1;
    rst4 = 1'b1;
    #4;
    m2 = 3;
    m4 = 9;
    tests_run++;
    if (out2 !== 2'd3) begin
      tests_failed++;
      $display("FAIL reset_release_hold: got %0d expected 3", out2);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin
      dec2 = 1'b1;
      #1;
      m2 = model_dec(m2, 2);
      tests_run++;
      if (out2 !== 2'(m2)) begin
        tests_failed++;
        $display("FAIL wrap_rise[%0d]: got %0d expected %0d", i, out2, m2);
      end
      #4;
      dec2 = 1'b0;
      #1;
      tests_run++;
      if (out2 !== 2'(m2)) begin
        tests_failed++;
        $display("FAIL wrap_fall_noeffect[%0d]: got %0d expected %0d", i, out2, m2);
      end
      #4;
    end
  endtask

  task automatic test_reset_hold_tracking();
    in2 = 2'd3;
    rst2 = 1'b0;
    #2;
    m2 = 3;
    pulse2();
    tests_run++;
    if (out2 !== 2'(m2)) begin
      tests_failed++;
      $display("FAIL hold_edge_no_dec: got %0d expected %0d", out2, m2);
    end
    in2 = 2'd1;
    #2;
    tests_run++;
    if (out2 !== 2'(m2)) begin
      tests_failed++;
      $display("FAIL hold_in_change_no_edge: got %0d expected %0d", out2, m2);
    end
    m2 = 1;
    for (int i = 0; i < 2; i++) begin
      pulse2();
      tests_run++;
      if (out2 !== 2'(m2)) begin
        tests_failed++;
        $display("FAIL hold_track_in[%0d]: got %0d expected %0d", i, out2, m2);
      end
    end
    rst2 = 1'b1;
    #3;
  endtask

  task automatic test_async_midcount();
    while (m2 != 1) begin
      pulse2();
      m2 = model_dec(m2, 2);
    end
    tests_run++;
    if (out2 !== 2'd1) begin
      tests_failed++;
      $display("FAIL midcount_setup: got %0d expected 1", out2);
    end
    in2 = 2'd2;
    dec2 = 1'b1;
    #1;
    m2 = model_dec(m2, 2);
    #1;
    rst2 = 1'b0;
    #1;
    m2 = 2;
    tests_run++;
    if (out2 !== 2'(m2)) begin
      tests_failed++;
      $display("FAIL midcount_async_preset: got %0d expected %0d", out2, m2);
    end
    dec2 = 1'b0;
    #2;
    rst2 = 1'b1;
    #3;
    pulse2();
    m2 = model_dec(m2, 2);
    tests_run++;
    if (out2 !== 2'(m2)) begin
      tests_failed++;
      $display("FAIL midcount_after_release: got %0d expected %0d", out2, m2);
    end
  endtask

  task automatic test_release_quiet();
    for (int i = 0; i < 4; i++) begin
      in2 = 2'($urandom_range(0, 3));
      rst2 = 1'b0;
      #2;
      m2 = int'(in2);
      rst2 = 1'b1;
      #3;
      pulse2();
      m2 = model_dec(m2, 2);
      tests_run++;
      if (out2 !== 2'(m2)) begin
        tests_failed++;
        $display("FAIL release_quiet[%0d]: got %0d expected %0d", i, out2, m2);
      end
    end
  endtask

  task automatic test_n4_wrap();
    in4 = 4'd0;
    rst4 = 1'b0;
    #2;
    m4 = 0;
    rst4 = 1'b1;
    #3;
    pulse4();
    m4 = model_dec(m4, 4);
    tests_run++;
    if (out4 !== 4'd15) begin
      tests_failed++;
      $display("FAIL n4_first_wrap: got %0d expected 15", out4);
    end
    for (int i = 0; i < 15; i++) begin
      pulse4();
      m4 = model_dec(m4, 4);
      tests_run++;
      if (out4 !== 4'(m4)) begin
        tests_failed++;
        $display("FAIL n4_count[%0d]: got %0d expected %0d", i, out4, m4);
      end
    end
    tests_run++;
    if (out4 !== 4'd0) begin
      tests_failed++;
      $display("FAIL n4_end_zero: got %0d expected 0", out4);
    end
  endtask

  task automatic test_random_n4();
    int op;
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 99));
      if (op < 70) begin
        in4 = 4'($urandom_range(0, 15));
        pulse4();
        m4 = model_dec(m4, 4);
      end else begin
        in4 = 4'($urandom_range(0, 15));
        #1;
        rst4 = 1'b0;
        #1;
        m4 = int'(in4);
        tests_run++;
        if (out4 !== 4'(m4)) begin
          tests_failed++;
          $display("FAIL rand_preset[%0d]: got %0d expected %0d", i, out4, m4);
        end
        if (op >= 85) begin
          in4 = 4'($urandom_range(0, 15));
          pulse4();
          m4 = int'(in4);
        end
        #1;
        rst4 = 1'b1;
        #3;
      end
      tests_run++;
      if (out4 !== 4'(m4)) begin
        tests_failed++;
        $display("FAIL rand_step[%0d]: got %0d expected %0d", i, out4, m4);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    m2 = 0;
    m4 = 0;
    in2 = '0;
    in4 = '0;
    dec2 = 1'b0;
    dec4 = 1'b0;
    rst2 = 1'b1;
    rst4 = 1'b1;

    test_reset();
    test_wrap();
    test_reset_hold_tracking();
    test_async_midcount();
    test_release_quiet();
    test_n4_wrap();
    test_random_n4();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
